// File: rtl/beat_window_packer.sv
// Packs per-sample beat flags into a sliding WINDOW_WIDTH-bit window and offers it every HOP samples.
// Optional sticky overrun flag with clear input is compiled in by defining BEAT_WINDOW_OVERRUN_EN.
module beat_window_packer #(
  parameter int WINDOW_WIDTH = 8,
  parameter int HOP          = 4
) (
  input  logic                                  clk_in,
  input  logic                                  rst_n_in,
  input  logic                                  sample_valid_in,
  input  logic                                  beat_in,
  input  logic                                  window_ready_in,
  output logic [WINDOW_WIDTH-1:0]               window_out,
  output logic                                  window_valid_out,
  output logic [$clog2(WINDOW_WIDTH+1)-1:0]     fill_out
`ifdef BEAT_WINDOW_OVERRUN_EN
  ,
  input  logic                                  overrun_clr_in,
  output logic                                  overrun_out
`endif
);

  localparam int W  = WINDOW_WIDTH;
  localparam int FW = $clog2(W + 1);
  localparam int HW = $clog2(HOP + 1);
  localparam logic [FW-1:0] FILL_MAX  = FW'(W);
  localparam logic [FW-1:0] FILL_LAST = FW'(W - 1);
  localparam logic [HW-1:0] HOP_LAST  = HW'(HOP - 1);

  typedef enum logic { FILLING = 1'b0, RUNNING = 1'b1 } fill_state_t;
  typedef enum logic { EMPTY = 1'b0, HELD = 1'b1 } out_state_t;

  // Only W-1 history bits are stored: the oldest bit of a window is never needed after it is emitted.
  logic [W-2:0]  sr, sr_next;
  logic [W-1:0]  shifted;
  logic [FW-1:0] fill, fill_next;
  logic [HW-1:0] hop_cnt, hop_next;
  fill_state_t   fstate, fstate_next;
  out_state_t    ostate, ostate_next;
  logic          emit;
  logic          load;

  assign shifted = {sr, beat_in};

  always_comb begin
    sr_next     = sr;
    fill_next   = fill;
    hop_next    = hop_cnt;
    fstate_next = fstate;
    emit        = 1'b0;
    if (sample_valid_in) begin
      sr_next = shifted[W-2:0];
      if (fill != FILL_MAX) begin
        fill_next = fill + 1'b1;
      end
      if (fstate == FILLING) begin
        hop_next = '0;
        if (fill == FILL_LAST) begin
          emit        = 1'b1;
          fstate_next = RUNNING;
        end
      end else if (hop_cnt == HOP_LAST) begin
        emit     = 1'b1;
        hop_next = '0;
      end else begin
        hop_next = hop_cnt + 1'b1;
      end
    end
  end

  // A held window is replaced only when it is consumed in the same cycle; otherwise the new one is lost.
  always_comb begin
    ostate_next = ostate;
    load        = 1'b0;
    if (ostate == EMPTY) begin
      if (emit) begin
        load        = 1'b1;
        ostate_next = HELD;
      end
    end else begin
      if (emit) begin
        load = window_ready_in;
      end else if (window_ready_in) begin
        ostate_next = EMPTY;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sr         <= '0;
      fill       <= '0;
      hop_cnt    <= '0;
      fstate     <= FILLING;
      ostate     <= EMPTY;
      window_out <= '0;
    end else begin
      sr      <= sr_next;
      fill    <= fill_next;
      hop_cnt <= hop_next;
      fstate  <= fstate_next;
      ostate  <= ostate_next;
      if (load) begin
        window_out <= shifted;
      end
    end
  end

  assign window_valid_out = (ostate == HELD);
  assign fill_out         = fill;

`ifdef BEAT_WINDOW_OVERRUN_EN
  logic drop;
  assign drop = emit && (ostate == HELD) && !window_ready_in;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      overrun_out <= 1'b0;
    end else if (drop) begin
      overrun_out <= 1'b1;
    end else if (overrun_clr_in) begin
      overrun_out <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_beat_window_packer.sv
// Randomized and directed bench for beat_window_packer against a sample-history reference model.
module tb_beat_window_packer;
  localparam int W   = 8;
  localparam int HOP = 4;

  logic         clk_in = 1'b0;
  logic         rst_n_in = 1'b0;
  logic         sample_valid_in = 1'b0;
  logic         beat_in = 1'b0;
  logic         window_ready_in = 1'b0;
  logic         overrun_clr_in = 1'b0;
  logic [W-1:0] window_out;
  logic         window_valid_out;
  logic [3:0]   fill_out;
`ifdef BEAT_WINDOW_OVERRUN_EN
  logic         overrun_out;
`endif

  beat_window_packer #(.WINDOW_WIDTH(W), .HOP(HOP)) dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .sample_valid_in  (sample_valid_in),
    .beat_in          (beat_in),
    .window_ready_in  (window_ready_in),
    .window_out       (window_out),
    .window_valid_out (window_valid_out),
    .fill_out         (fill_out)
`ifdef BEAT_WINDOW_OVERRUN_EN
    ,
    .overrun_clr_in   (overrun_clr_in),
    .overrun_out      (overrun_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  int passed = 0;
  int total  = 0;

  // Reference model: history of accepted samples since reset plus the output hand-off state.
  bit           q[$];
  int           n;
  int           m_fill;
  logic [W-1:0] m_window;
  logic         m_valid;
  logic         m_ovr;

  function automatic logic [W-1:0] newest_window();
    logic [W-1:0] w = '0;
    for (int i = 0; i < q.size() && i < W; i++) w[i] = q[q.size()-1-i];
    return w;
  endfunction

  task automatic model_clear();
    q.delete();
    n = 0; m_fill = 0; m_window = '0; m_valid = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic cyc();
    bit emit;
    bit drop;
    @(posedge clk_in);
    emit = 1'b0;
    drop = 1'b0;
    if (rst_n_in) begin
      if (sample_valid_in) begin
        q.push_back(beat_in);
        if (q.size() > W) void'(q.pop_front());
        n++;
        m_fill = (n < W) ? n : W;
        emit = (n == W) || (n > W && ((n - W) % HOP) == 0);
      end
      if (emit) begin
        if (!m_valid || window_ready_in) begin
          m_window = newest_window();
          m_valid  = 1'b1;
        end else begin
          drop = 1'b1;
        end
      end else if (m_valid && window_ready_in) begin
        m_valid = 1'b0;
      end
      if (drop) m_ovr = 1'b1;
      else if (overrun_clr_in) m_ovr = 1'b0;
    end
    #1;
  endtask

  task automatic sample(input bit b, input bit rdy);
    sample_valid_in = 1'b1; beat_in = b; window_ready_in = rdy;
    cyc();
    sample_valid_in = 1'b0;
  endtask

  task automatic idle(input bit rdy);
    sample_valid_in = 1'b0; window_ready_in = rdy;
    cyc();
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    model_clear();
    for (int i = 0; i < 5; i++) begin
      sample_valid_in = 1'($urandom); beat_in = 1'($urandom);
      window_ready_in = 1'($urandom); overrun_clr_in = 1'($urandom);
      cyc();
      total++; if (window_out !== 8'h00) $display("FAIL reset_window got %h want 00", window_out); else passed++;
      total++; if (window_valid_out !== 1'b0) $display("FAIL reset_valid got %b want 0", window_valid_out); else passed++;
      total++; if (fill_out !== 4'd0) $display("FAIL reset_fill got %0d want 0", fill_out); else passed++;
`ifdef BEAT_WINDOW_OVERRUN_EN
      total++; if (overrun_out !== 1'b0) $display("FAIL reset_overrun got %b want 0", overrun_out); else passed++;
`endif
    end
    rst_n_in = 1'b1; overrun_clr_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      beat_in = 1'($urandom);
      idle(1'($urandom));
      total++; if (window_valid_out !== 1'b0 || window_out !== 8'h00 || fill_out !== 4'd0)
        $display("FAIL idle_after_reset got v=%b w=%h f=%0d want v=0 w=00 f=0", window_valid_out, window_out, fill_out);
      else passed++;
    end
  endtask

  task automatic test_first_fill();
    bit seq [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      sample(seq[i], 1'b1);
      total++; if (window_valid_out !== m_valid || window_valid_out !== (i == 7))
        $display("FAIL fill_valid[%0d] got %b want %b", i, window_valid_out, m_valid);
      else passed++;
      total++; if (fill_out !== 4'(m_fill)) $display("FAIL fill_count[%0d] got %0d want %0d", i, fill_out, m_fill); else passed++;
    end
    total++; if (window_out !== 8'h91 || window_out !== m_window) $display("FAIL first_window got %h want 91", window_out); else passed++;
    total++; if (fill_out !== 4'd8) $display("FAIL first_fill_sat got %0d want 8", fill_out); else passed++;
    idle(1'b1);
    total++; if (window_valid_out !== 1'b0) $display("FAIL first_valid_pulse got %b want 0", window_valid_out); else passed++;
    total++; if (window_out !== 8'h91) $display("FAIL window_kept got %h want 91", window_out); else passed++;
  endtask

  task automatic test_hop();
    bit seq [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      sample(seq[i], 1'b1);
      total++; if (window_valid_out !== m_valid || window_valid_out !== (i == 3))
        $display("FAIL hop_valid[%0d] got %b want %b", i, window_valid_out, m_valid);
      else passed++;
    end
    total++; if (window_out !== 8'h1C || window_out !== m_window) $display("FAIL hop_window got %h want 1c", window_out); else passed++;
    total++; if (fill_out !== 4'd8) $display("FAIL hop_fill got %0d want 8", fill_out); else passed++;
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      total++; if (window_valid_out !== 1'b1 || window_out !== 8'h1C)
        $display("FAIL bp_hold got v=%b w=%h want v=1 w=1c", window_valid_out, window_out);
      else passed++;
    end
    for (int i = 0; i < 4; i++) sample(1'($urandom), 1'b0);
    total++; if (window_valid_out !== 1'b1 || window_out !== 8'h1C)
      $display("FAIL bp_drop_data got v=%b w=%h want v=1 w=1c", window_valid_out, window_out);
    else passed++;
`ifdef BEAT_WINDOW_OVERRUN_EN
    total++; if (overrun_out !== 1'b1) $display("FAIL bp_overrun_set got %b want 1", overrun_out); else passed++;
`endif
    idle(1'b1);
    total++; if (window_valid_out !== 1'b0 || window_out !== 8'h1C)
      $display("FAIL bp_consume got v=%b w=%h want v=0 w=1c", window_valid_out, window_out);
    else passed++;
    idle(1'b0);
    idle(1'b0);
`ifdef BEAT_WINDOW_OVERRUN_EN
    total++; if (overrun_out !== 1'b1) $display("FAIL bp_overrun_sticky got %b want 1", overrun_out); else passed++;
`endif
    overrun_clr_in = 1'b1;
    idle(1'b0);
    overrun_clr_in = 1'b0;
`ifdef BEAT_WINDOW_OVERRUN_EN
    total++; if (overrun_out !== 1'b0) $display("FAIL bp_overrun_clear got %b want 0", overrun_out); else passed++;
`endif
  endtask

  task automatic test_simultaneous();
    logic [W-1:0] first;
    for (int i = 0; i < 4; i++) sample(1'(i), 1'b0);
    first = m_window;
    total++; if (window_valid_out !== 1'b1 || window_out !== first)
      $display("FAIL sim_load got v=%b w=%h want v=1 w=%h", window_valid_out, window_out, first);
    else passed++;
    for (int i = 0; i < 3; i++) sample(1'b1, 1'b0);
    sample(1'b1, 1'b1);
    total++; if (window_valid_out !== 1'b1 || window_out !== m_window || m_window === first)
      $display("FAIL sim_ready_emit got v=%b w=%h want v=1 w=%h", window_valid_out, window_out, m_window);
    else passed++;
`ifdef BEAT_WINDOW_OVERRUN_EN
    total++; if (overrun_out !== 1'b0) $display("FAIL sim_no_overrun got %b want 0", overrun_out); else passed++;
`endif
    for (int i = 0; i < 3; i++) sample(1'b0, 1'b0);
    overrun_clr_in = 1'b1;
    sample(1'b0, 1'b0);
    overrun_clr_in = 1'b0;
    total++; if (window_out !== m_window || window_valid_out !== 1'b1)
      $display("FAIL sim_drop_data got v=%b w=%h want v=1 w=%h", window_valid_out, window_out, m_window);
    else passed++;
`ifdef BEAT_WINDOW_OVERRUN_EN
    total++; if (overrun_out !== 1'b1) $display("FAIL sim_set_wins got %b want 1", overrun_out); else passed++;
`endif
  endtask

  task automatic test_reset_mid();
    rst_n_in = 1'b0; model_clear(); #1;
    total++; if (window_valid_out !== 1'b0 || fill_out !== 4'd0 || window_out !== 8'h00)
      $display("FAIL async_reset got v=%b f=%0d w=%h want 0s", window_valid_out, fill_out, window_out);
    else passed++;
    rst_n_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sample(1'($urandom), 1'b1);
      total++; if (fill_out !== 4'(i + 1)) $display("FAIL mid_fill[%0d] got %0d want %0d", i, fill_out, i + 1); else passed++;
    end
    rst_n_in = 1'b0; model_clear(); #1;
    total++; if (fill_out !== 4'd0) $display("FAIL mid_reset_fill got %0d want 0", fill_out); else passed++;
    rst_n_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sample(1'($urandom), 1'b1);
      total++; if (window_valid_out !== (i == 7) || window_valid_out !== m_valid)
        $display("FAIL refill_valid[%0d] got %b want %b", i, window_valid_out, m_valid);
      else passed++;
    end
    total++; if (window_out !== m_window) $display("FAIL refill_window got %h want %h", window_out, m_window); else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        rst_n_in = 1'b0; model_clear(); #1; rst_n_in = 1'b1;
      end
      sample_valid_in = ($urandom_range(0, 3) != 0);
      beat_in         = 1'($urandom);
      window_ready_in = ($urandom_range(0, 2) == 0);
      overrun_clr_in  = ($urandom_range(0, 15) == 0);
      cyc();
      total++; if (window_valid_out !== m_valid) $display("FAIL rand_valid[%0d] got %b want %b", i, window_valid_out, m_valid); else passed++;
      total++; if (window_out !== m_window) $display("FAIL rand_window[%0d] got %h want %h", i, window_out, m_window); else passed++;
      total++; if (fill_out !== 4'(m_fill)) $display("FAIL rand_fill[%0d] got %0d want %0d", i, fill_out, m_fill); else passed++;
`ifdef BEAT_WINDOW_OVERRUN_EN
      total++; if (overrun_out !== m_ovr) $display("FAIL rand_overrun[%0d] got %b want %b", i, overrun_out, m_ovr); else passed++;
`endif
    end
    sample_valid_in = 1'b0; overrun_clr_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_fill();
    test_hop();
    test_backpressure();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
